mtx_multitone_hop_gen: RTL and testbench
========================================

# mtx_multitone_hop_gen

Multi-tone, frequency-hopping phase generator for the main ANC transmit path. Each hop is requested by one hop word on a handshaked input. The block emits NTONES phase words per sample, with a per-symbol chirp step and a per-symbol start-phase shift, on a back-pressurable AXI-stream. Downstream, one DDS LUT per tone and an add/clip tree turn the phases into I/Q. The block replaces fixed two-tone generation: tone count is a parameter, output backpressure is honoured, and the next hop is buffered so back-to-back hops have no gap.

## Interface
- PHASE_WIDTH, 24: phase and increment word width.
- NTONES, 4: tone count, at least 1.
- CNT_WIDTH, 16: sample and symbol counter width.
- TX_SYNC_BITS, 3: hop counter width for sync_ready.
- NSIG, 8192: samples per symbol, at least 1.
- NSYMB, 9: symbols per hop, at least 1.
- DPH_INC, 16384: increment added per symbol.
- FREQ_SHIFT, 4096: increment spacing between adjacent tones.
- START_PH, 0: start phase of symbol 0.
- NPH_SHIFT, 0: start-phase decrement per symbol.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- srst  in  1  synchronous clear, same effect as reset.
- hop_tvalid  in  1  hop word valid.
- hop_tready  out  1  hop buffer empty.
- hop_phase_inc  in  PHASE_WIDTH  base increment of tone 0.
- out_tvalid  out  1  sample valid.
- out_tready  in  1  downstream ready.
- out_tlast  out  1  last sample of the hop.
- out_tdata  out  NTONES*PHASE_WIDTH  tone k phase in bits [k*PW +: PW].
- hop_done  out  1  one-cycle pulse at hop end.
- sync_ready  out  1  see Configuration.
- sigN  out  CNT_WIDTH  current sample index, 0-based.
- symbN  out  CNT_WIDTH  current symbol index, 0-based.

## Operation
- Hop buffer: one entry.
  - hop_tready is registered and equals NOT buf_valid.
  - A transfer occurs on hop_tvalid && hop_tready and sets buf_valid.
- States: IDLE and RUN.
  - IDLE: out_tvalid=0. When buf_valid=1, load the buffer, clear buf_valid, set n=0, s=0, go to RUN.
  - RUN: out_tvalid=1. Advance only on a beat (out_tvalid && out_tready).
- Sample phase for n in 0..NSIG-1, s in 0..NSYMB-1, k in 0..NTONES-1:
  - sp(s) = START_PH − s·NPH_SHIFT
  - inc_k(s) = hop + k·FREQ_SHIFT + s·DPH_INC
  - phase_k = sp(s) + n·inc_k(s)
  - All arithmetic is mod 2^PHASE_WIDTH with silent wrap.
- Implement phase_k incrementally with per-tone accumulators and per-tone increment registers; no multipliers. k·FREQ_SHIFT is an elaboration constant.
- On a beat with n=NSIG−1 and s<NSYMB−1: n=0, s+1, increments += DPH_INC, sp −= NPH_SHIFT.
- On a beat with n=NSIG−1 and s=NSYMB−1 (hop end):
  - Pulse hop_done.
  - If buf_valid: load the next hop seamlessly with no out_tvalid gap.
  - Else: go to IDLE.
- out_tlast=1 only on the last sample of the last symbol.
- srst, or reset mid-operation: the current hop and the buffered hop are discarded.

## Timing
- Values during reset:
  - out_tvalid=0, out_tlast=0, hop_done=0, hop_tready=0.
  - out_tdata: every tone START_PH.
  - sigN=0, symbN=0, buf_valid=0, state IDLE.
  - sync_ready=1 with the macro defined, 0 without it.
- hop_tready rises on the first clk edge after reset deasserts.
- A hop accepted at edge t while IDLE gives out_tvalid=1 after edge t+1. Sample 0 has all tones at START_PH.
- out_tdata, out_tlast, sigN and symbN are registered. They hold stable while out_tvalid && !out_tready.
- The hop buffer refills during RUN, so a hop accepted any time before the hop-end beat follows with zero idle cycles.
- hop_done is high for exactly the cycle after the hop-end beat.
- NSIG=1: every sample is a symbol end. NSYMB=1: every symbol end is a hop end.

## Configuration
- MTX_HOP_SYNC_EN defined:
  - A TX_SYNC_BITS counter resets to all ones and increments at each hop end.
  - sync_ready = &counter, so it is high before the first hop and then for one hop in every 2^TX_SYNC_BITS.
- MTX_HOP_SYNC_EN undefined: no counter; sync_ready is tied to 0.

## Test plan
- Basic hop. Setup: NTONES=2, NSIG=4, NSYMB=2, hop=1000, FREQ_SHIFT=4096, DPH_INC=16384, START_PH=0, NPH_SHIFT=0.
  - Symbol 0: tone0 = 0, 1000, 2000, 3000; tone1 = 0, 5096, 10192, 15288.
  - Symbol 1: tone0 = 0, 17384, 34768, 52152.
  - out_tlast on beat 8; hop_done one cycle later.
- Wrap: START_PH=24'hFFFFF0, hop=24'h20, NPH_SHIFT=16 -> tone0 symbol 0 = FFFFF0, 000010; symbol 1 starts at FFFFE0.
- Backpressure: deassert out_tready for 5 cycles mid-symbol -> out_tdata and sigN frozen, no sample lost or duplicated.
- Back-to-back: second hop word accepted during hop 1 -> out_tvalid stays high across the boundary and hop 2 sample 0 is START_PH. A third word is stalled (hop_tready=0) until the buffer drains.
- Reset: assert reset mid-symbol -> next cycle out_tvalid=0, out_tdata all START_PH, buffered hop discarded. srst gives the same result synchronously.
- Sync, with MTX_HOP_SYNC_EN and TX_SYNC_BITS=2: sync_ready=1 after reset, 0 after hops 1–3, 1 after hop 4. Without the macro it stays 0.

Source files
------------

// File: rtl/mtx_multitone_hop_gen.sv
// Multi-tone frequency-hopping phase generator with a one-entry hop buffer and AXI-stream output.
// Defining MTX_HOP_SYNC_EN adds a hop counter that drives sync_ready; otherwise sync_ready is 0.
module mtx_multitone_hop_gen #(
    parameter int PHASE_WIDTH  = 24,
    parameter int NTONES       = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int TX_SYNC_BITS = 3,
    parameter int NSIG         = 8192,
    parameter int NSYMB        = 9,
    parameter logic [PHASE_WIDTH-1:0] DPH_INC    = PHASE_WIDTH'(16384),
    parameter logic [PHASE_WIDTH-1:0] FREQ_SHIFT = PHASE_WIDTH'(4096),
    parameter logic [PHASE_WIDTH-1:0] START_PH   = PHASE_WIDTH'(0),
    parameter logic [PHASE_WIDTH-1:0] NPH_SHIFT  = PHASE_WIDTH'(0)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          srst,
    input  logic                          hop_tvalid,
    output logic                          hop_tready,
    input  logic [PHASE_WIDTH-1:0]        hop_phase_inc,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic                          out_tlast,
    output logic [NTONES*PHASE_WIDTH-1:0] out_tdata,
    output logic                          hop_done,
    output logic                          sync_ready,
    output logic [CNT_WIDTH-1:0]          sigN,
    output logic [CNT_WIDTH-1:0]          symbN
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_nxt;
    logic                   buf_valid, buf_valid_nxt;
    logic [PHASE_WIDTH-1:0] buf_inc;
    logic [PHASE_WIDTH-1:0] acc [NTONES];
    logic [PHASE_WIDTH-1:0] acc_nxt [NTONES];
    logic [PHASE_WIDTH-1:0] inc [NTONES];
    logic [PHASE_WIDTH-1:0] inc_nxt [NTONES];
    logic [PHASE_WIDTH-1:0] sp, sp_nxt;
    logic [CNT_WIDTH-1:0]   sig_nxt, symb_nxt;
    logic                   tlast_nxt;
    logic                   beat, last_sig, last_symb, hop_end, load, accept;

    assign out_tvalid = (state == RUN);
    assign beat       = out_tvalid && out_tready;
    assign last_sig   = (sigN == CNT_WIDTH'(NSIG - 1));
    assign last_symb  = (symbN == CNT_WIDTH'(NSYMB - 1));
    assign hop_end    = beat && last_sig && last_symb;
    assign load       = buf_valid && ((state == IDLE) || hop_end);
    assign accept     = hop_tvalid && hop_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (buf_valid) state_nxt = RUN;
            RUN:     if (hop_end && !buf_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (srst) state_nxt = IDLE;
    end

    // Accept and load are exclusive: a transfer needs an empty buffer, a load a full one.
    always_comb begin
        buf_valid_nxt = buf_valid;
        if (load)   buf_valid_nxt = 1'b0;
        if (accept) buf_valid_nxt = 1'b1;
        if (srst)   buf_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid  <= 1'b0;
            hop_tready <= 1'b0;
            buf_inc    <= '0;
        end else begin
            buf_valid  <= buf_valid_nxt;
            hop_tready <= !buf_valid_nxt && !srst;
            if (accept) buf_inc <= hop_phase_inc;
        end
    end

    always_comb begin
        acc_nxt  = acc;
        inc_nxt  = inc;
        sp_nxt   = sp;
        sig_nxt  = sigN;
        symb_nxt = symbN;
        if (load) begin
            for (int k = 0; k < NTONES; k++) begin
                inc_nxt[k] = buf_inc + PHASE_WIDTH'(k) * FREQ_SHIFT;
                acc_nxt[k] = START_PH;
            end
            sp_nxt   = START_PH;
            sig_nxt  = '0;
            symb_nxt = '0;
        end else if (hop_end) begin
            for (int k = 0; k < NTONES; k++) acc_nxt[k] = START_PH;
            sp_nxt   = START_PH;
            sig_nxt  = '0;
            symb_nxt = '0;
        end else if (beat) begin
            // A symbol boundary restarts every tone at the shifted start phase with a steeper chirp.
            if (last_sig) begin
                sp_nxt = sp - NPH_SHIFT;
                for (int k = 0; k < NTONES; k++) begin
                    acc_nxt[k] = sp - NPH_SHIFT;
                    inc_nxt[k] = inc[k] + DPH_INC;
                end
                sig_nxt  = '0;
                symb_nxt = symbN + CNT_WIDTH'(1);
            end else begin
                for (int k = 0; k < NTONES; k++) acc_nxt[k] = acc[k] + inc[k];
                sig_nxt = sigN + CNT_WIDTH'(1);
            end
        end
        if (srst) begin
            for (int k = 0; k < NTONES; k++) begin
                acc_nxt[k] = START_PH;
                inc_nxt[k] = '0;
            end
            sp_nxt   = START_PH;
            sig_nxt  = '0;
            symb_nxt = '0;
        end
        tlast_nxt = (state_nxt == RUN) && (sig_nxt == CNT_WIDTH'(NSIG - 1))
                    && (symb_nxt == CNT_WIDTH'(NSYMB - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NTONES; k++) begin
                acc[k] <= START_PH;
                inc[k] <= '0;
            end
            sp        <= START_PH;
            sigN      <= '0;
            symbN     <= '0;
            out_tlast <= 1'b0;
            hop_done  <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            inc       <= inc_nxt;
            sp        <= sp_nxt;
            sigN      <= sig_nxt;
            symbN     <= symb_nxt;
            out_tlast <= tlast_nxt;
            hop_done  <= hop_end && !srst;
        end
    end

    for (genvar g = 0; g < NTONES; g++) begin : g_tdata
        assign out_tdata[g*PHASE_WIDTH +: PHASE_WIDTH] = acc[g];
    end

`ifdef MTX_HOP_SYNC_EN
    logic [TX_SYNC_BITS-1:0] sync_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        sync_cnt <= '1;
        else if (srst)    sync_cnt <= '1;
        else if (hop_end) sync_cnt <= sync_cnt + TX_SYNC_BITS'(1);
    end

    assign sync_ready = &sync_cnt;
`else
    assign sync_ready = 1'b0;
`endif

endmodule

// File: tb/tb_mtx_multitone_hop_gen.sv
// Self-checking bench for mtx_multitone_hop_gen: two instances (plain and wrapping start phase)
// share one stimulus stream and are compared every cycle against a per-hop arithmetic model.
module tb_mtx_multitone_hop_gen;

    localparam int PW     = 24;
    localparam int NT     = 2;
    localparam int CW     = 16;
    localparam int NSIG   = 4;
    localparam int NSYMB  = 2;
    localparam int HOPLEN = NSIG * NSYMB;
    localparam logic [23:0] START1 = 24'hFFFFF0;
    localparam logic [23:0] NPH1   = 24'd16;

    logic            clk, reset, srst, hop_tvalid, out_tready;
    logic [PW-1:0]   hop_phase_inc;
    logic            hop_tready [2];
    logic            out_tvalid [2];
    logic            out_tlast [2];
    logic            hop_done [2];
    logic            sync_ready [2];
    logic [NT*PW-1:0] out_tdata [2];
    logic [CW-1:0]   sigN [2];
    logic [CW-1:0]   symbN [2];

    int errors = 0;
    int checks = 0;

    logic [23:0] hq [2][64];
    int          hd [2];
    int          tl [2];
    int          bidx [2];
    int          hcount [2];
    int          hseq [2];
    bit          doneExp [2];
    bit          gapExp [2];
    logic [23:0] recA [HOPLEN][NT];
    logic [23:0] recB [HOPLEN][NT];

    mtx_multitone_hop_gen #(
        .PHASE_WIDTH(PW), .NTONES(NT), .CNT_WIDTH(CW), .TX_SYNC_BITS(2),
        .NSIG(NSIG), .NSYMB(NSYMB), .DPH_INC(24'd16384), .FREQ_SHIFT(24'd4096),
        .START_PH(24'd0), .NPH_SHIFT(24'd0)
    ) dut0 (
        .clk(clk), .reset(reset), .srst(srst),
        .hop_tvalid(hop_tvalid), .hop_tready(hop_tready[0]), .hop_phase_inc(hop_phase_inc),
        .out_tvalid(out_tvalid[0]), .out_tready(out_tready), .out_tlast(out_tlast[0]),
        .out_tdata(out_tdata[0]), .hop_done(hop_done[0]), .sync_ready(sync_ready[0]),
        .sigN(sigN[0]), .symbN(symbN[0])
    );

    mtx_multitone_hop_gen #(
        .PHASE_WIDTH(PW), .NTONES(NT), .CNT_WIDTH(CW), .TX_SYNC_BITS(2),
        .NSIG(NSIG), .NSYMB(NSYMB), .DPH_INC(24'd16384), .FREQ_SHIFT(24'd4096),
        .START_PH(START1), .NPH_SHIFT(NPH1)
    ) dut1 (
        .clk(clk), .reset(reset), .srst(srst),
        .hop_tvalid(hop_tvalid), .hop_tready(hop_tready[1]), .hop_phase_inc(hop_phase_inc),
        .out_tvalid(out_tvalid[1]), .out_tready(out_tready), .out_tlast(out_tlast[1]),
        .out_tdata(out_tdata[1]), .hop_done(hop_done[1]), .sync_ready(sync_ready[1]),
        .sigN(sigN[1]), .symbN(symbN[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] startOf(int i);
        return (i == 0) ? 24'd0 : START1;
    endfunction

    // Closed-form phase: start phase minus per-symbol shift, plus n times the tone's chirped increment.
    function automatic logic [23:0] expPhase(int i, logic [23:0] hop, int k, int n, int s);
        logic [23:0] nph, incv, spv;
        nph  = (i == 0) ? 24'd0 : NPH1;
        incv = hop + 24'(k) * 24'd4096 + 24'(s) * 24'd16384;
        spv  = startOf(i) - 24'(s) * nph;
        return spv + 24'(n) * incv;
    endfunction

    function automatic logic expSync(int h);
`ifdef MTX_HOP_SYNC_EN
        return (h % 4) == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flushModel();
        for (int i = 0; i < 2; i++) begin
            hd[i]      = tl[i];
            bidx[i]    = 0;
            hcount[i]  = 0;
            doneExp[i] = 1'b0;
            gapExp[i]  = 1'b0;
        end
    endtask

    task automatic checkResetState();
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_tvalid", out_tvalid[i], 0);
            checkOutput("rst_tlast", out_tlast[i], 0);
            checkOutput("rst_hop_done", hop_done[i], 0);
            checkOutput("rst_hop_tready", hop_tready[i], 0);
            checkOutput("rst_tdata", out_tdata[i], {startOf(i), startOf(i)});
            checkOutput("rst_sigN", sigN[i], 0);
            checkOutput("rst_symbN", symbN[i], 0);
            checkOutput("rst_sync_ready", sync_ready[i], expSync(0));
        end
    endtask

    // Hold one hop word valid until the bench sees it accepted.
    task automatic applyStimulus(input logic [23:0] hop);
        bit ok = 1'b0;
        hop_phase_inc = hop;
        hop_tvalid    = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (hop_tready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        hop_tvalid = 1'b0;
        checkOutput("hop_accept_timeout", ok, 1);
    endtask

    task automatic waitHops(input int target);
        bit ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (hseq[0] >= target) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        checkOutput("hop_end_timeout", ok, 1);
    endtask

    task automatic waitSig(input int v);
        bit ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_tvalid[0] && sigN[0] == CW'(v)) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        checkOutput("sample_wait_timeout", ok, 1);
    endtask

    // Compare process: one pass per cycle at the falling edge, then advance the model for the next rising edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            hd[i] = 0; tl[i] = 0; hseq[i] = 0;
        end
        flushModel();
        forever begin
            @(negedge clk);
            if (reset) begin
                flushModel();
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                checkOutput("hop_done", hop_done[i], doneExp[i]);
                if (gapExp[i]) checkOutput("gapless_tvalid", out_tvalid[i], 1);
                checkOutput("sync_ready", sync_ready[i], expSync(hcount[i]));
                if (out_tvalid[i]) begin
                    if (hd[i] == tl[i]) begin
                        checkOutput("beat_without_hop", out_tvalid[i], 0);
                    end else begin
                        int n, s;
                        n = bidx[i] % NSIG;
                        s = bidx[i] / NSIG;
                        for (int k = 0; k < NT; k++) begin
                            checkOutput("tone_phase", out_tdata[i][k*PW +: PW],
                                        expPhase(i, hq[i][hd[i]], k, n, s));
                            if (i == 0 && hseq[0] == 0) recA[bidx[i]][k] = out_tdata[i][k*PW +: PW];
                            if (i == 1 && hseq[1] == 1) recB[bidx[i]][k] = out_tdata[i][k*PW +: PW];
                        end
                        checkOutput("sigN", sigN[i], n);
                        checkOutput("symbN", symbN[i], s);
                        checkOutput("tlast", out_tlast[i], (bidx[i] == HOPLEN - 1));
                    end
                end else begin
                    checkOutput("tlast_idle", out_tlast[i], 0);
                end
            end
            if (srst) begin
                flushModel();
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                doneExp[i] = 1'b0;
                gapExp[i]  = 1'b0;
                if (out_tvalid[i] && out_tready && hd[i] != tl[i]) begin
                    bidx[i]++;
                    if (bidx[i] == HOPLEN) begin
                        bidx[i]    = 0;
                        hd[i]++;
                        hcount[i]++;
                        hseq[i]++;
                        doneExp[i] = 1'b1;
                        gapExp[i]  = (hd[i] != tl[i]);
                    end
                end
                if (hop_tvalid && hop_tready[i]) begin
                    hq[i][tl[i]] = hop_phase_inc;
                    tl[i]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int target;
        reset = 1'b1; srst = 1'b0; hop_tvalid = 1'b0; out_tready = 1'b1; hop_phase_inc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("tready_before_edge", hop_tready[0], 0);
        @(negedge clk);
        checkOutput("tready_after_edge", hop_tready[0], 1);
        @(posedge clk); #1;

        $display("[TB] basic hop");
        applyStimulus(24'd1000);
        waitHops(1);
        checkOutput("basic_t0_n0", recA[0][0], 24'd0);
        checkOutput("basic_t0_n1", recA[1][0], 24'd1000);
        checkOutput("basic_t0_n2", recA[2][0], 24'd2000);
        checkOutput("basic_t0_n3", recA[3][0], 24'd3000);
        checkOutput("basic_t1_n0", recA[0][1], 24'd0);
        checkOutput("basic_t1_n1", recA[1][1], 24'd5096);
        checkOutput("basic_t1_n2", recA[2][1], 24'd10192);
        checkOutput("basic_t1_n3", recA[3][1], 24'd15288);
        checkOutput("basic_s1_n0", recA[4][0], 24'd0);
        checkOutput("basic_s1_n1", recA[5][0], 24'd17384);
        checkOutput("basic_s1_n2", recA[6][0], 24'd34768);
        checkOutput("basic_s1_n3", recA[7][0], 24'd52152);

        $display("[TB] backpressure and back-to-back hops");
        applyStimulus(24'h20);
        waitSig(1);
        out_tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_sigN", sigN[0], 2);
            checkOutput("stall_tone0", out_tdata[0][23:0], 24'h40);
        end
        @(posedge clk); #1;
        out_tready = 1'b1;
        applyStimulus(24'd3000);
        @(negedge clk);
        checkOutput("third_word_stalled", hop_tready[0], 0);
        @(posedge clk); #1;
        applyStimulus(24'd5000);
        applyStimulus(24'd7);
        waitHops(5);
        checkOutput("wrap_t0_n0", recB[0][0], 24'hFFFFF0);
        checkOutput("wrap_t0_n1", recB[1][0], 24'h000010);
        checkOutput("wrap_t1_n1", recB[1][1], 24'h001010);
        checkOutput("wrap_s1_t0", recB[4][0], 24'hFFFFE0);
        checkOutput("wrap_s1_t1", recB[4][1], 24'hFFFFE0);
        checkOutput("wrap_s1_n1", recB[5][0], 24'h004000);

        $display("[TB] async reset mid-symbol");
        applyStimulus(24'd111);
        applyStimulus(24'd222);
        waitSig(2);
        reset = 1'b1;
        #1;
        checkResetState();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("reset_discard_0", out_tvalid[0], 0);
        checkOutput("reset_discard_1", out_tvalid[1], 0);
        @(posedge clk); #1;

        $display("[TB] synchronous clear mid-symbol");
        applyStimulus(24'd333);
        applyStimulus(24'd444);
        waitSig(2);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        checkResetState();
        repeat (20) @(negedge clk);
        checkOutput("srst_discard_0", out_tvalid[0], 0);
        checkOutput("srst_discard_1", out_tvalid[1], 0);
        @(posedge clk); #1;

        target = hseq[0] + 1;
        applyStimulus(24'd555);
        waitHops(target);
        repeat (3) @(negedge clk);
        checkOutput("model_queue_drained", tl[0] - hd[0], 0);
        checkOutput("idle_after_drain", out_tvalid[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
